lsu: RTL
========

# lsu

Load/store unit sitting directly downstream of the MEM stage: it turns the stage's memory request (read/write, size, signedness, address, store data) into a single Wishbone classic cycle on the core's data port. It returns aligned, sign- or zero-extended load data plus exception flags to the MEM stage, and stalls the pipeline while a bus cycle is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without ack/err before forced fault (only with LSU_TIMEOUT_EN)
- clk_i  in  1  core clock
- rst_i  in  1  reset, synchronous, active-high
- lsu_addr_i  in  32  byte address
- lsu_dat_i  in  32  store data, LSB-justified
- lsu_read_i / lsu_write_i  in  1  request strobes, held by MEM stage while lsu_stall_o=1
- lsu_byte_i / lsu_hw_i  in  1  size; neither = word
- lsu_unsigned_i  in  1  zero-extend load
- lsu_kill_i  in  1  flush of current MEM instruction
- lsu_dat_o  out  32  extended load data, valid with lsu_ready_o
- lsu_ready_o  out  1  one-cycle completion pulse
- lsu_stall_o  out  1  hold pipeline
- lsu_load_misaligned_o / lsu_store_misaligned_o  out  1  alignment exceptions, valid with lsu_ready_o
- lsu_load_fault_o / lsu_store_fault_o  out  1  bus error exceptions, valid with lsu_ready_o
- lsu_bad_addr_o  out  32  faulting address (mtval source)
- dwbm_dat_i  in  32; dwbm_ack_i, dwbm_err_i  in  1
- dwbm_addr_o  out  32 (word-aligned); dwbm_dat_o  out  32; dwbm_sel_o  out  4; dwbm_cyc_o, dwbm_stb_o, dwbm_we_o  out  1

## Operation
- States IDLE, BUSY, DONE. Reset: IDLE, all outputs 0.
- IDLE, request (read|write) and !kill: latch addr/size/signedness/data. Aligned → BUSY, cyc=stb=1, we=write. Misaligned (hw with addr[0]; word with addr[1:0]≠0) → DONE with misaligned flag, no bus cycle.
- read and write both set: treated as write.
- sel: byte 4'b0001<<addr[1:0]; hw 4'b0011<<{addr[1],1'b0}; word 4'b1111. Store data replicated: byte {4{d[7:0]}}, hw {2{d[15:0]}}.
- BUSY: hold all dwbm outputs stable. ack → DONE, capture load data: shift right by 8*addr[1:0], sign/zero-extend from bit 7/15. err → DONE with fault flag, data 0. ack and err together: err wins.
- DONE: lsu_ready_o=1 with data/flags for exactly one cycle; return to IDLE unconditionally (one bubble between back-to-back accesses).
- lsu_stall_o = BUSY | (IDLE & request & !kill). Low in DONE so the pipeline advances.
- Kill in BUSY: bus cycle runs to completion (no abort); DONE then suppresses ready_o and all flags.
- lsu_bad_addr_o = latched addr on any exception, else 0.

## Timing
- Request seen in cycle 0 → cyc/stb high from cycle 1 (registered).
- ack in cycle n → cyc/stb low and ready_o high in cycle n+1. Minimum latency: ack in cycle 1, ready in cycle 2.
- Misaligned: ready_o with flag in cycle 1, stall high only in cycle 0.
- Reset mid-cycle: cyc/stb drop on the next edge, state IDLE; in-flight result lost.

## Configuration
- LSU_TIMEOUT_EN defined: 8-bit-or-wider counter cleared on entry to BUSY, increments each BUSY cycle without ack/err. At TIMEOUT_CYCLES it acts as err: drop cyc/stb, go to DONE with fault.
- Undefined: no counter; BUSY waits indefinitely.

## Structure
- Shared package core_pkg: lsu state enum, size encoding, SEL_BYTE/SEL_HW/SEL_WORD constants.
- One combinational sub-module lsu_align: sel generation, store replication, load shift/extension.

## Test plan
- Word load 0x100, ack after 3 wait cycles, data 0xDEADBEEF → sel 1111, ready with 0xDEADBEEF; stall high until ack+1.
- Signed byte load 0x103, dwbm_dat_i 0x80000000 → sel 1000, lsu_dat_o 0xFFFFFF80; unsigned → 0x00000080.
- Halfword store 0x202 data 0x0000ABCD → sel 1100, dwbm_dat_o 0xABCDABCD, we=1.
- Word load 0x101 → no cyc, load_misaligned with ready in cycle 1, bad_addr 0x101.
- Store 0x300 with ack and err in the same cycle → store_fault, bad_addr 0x300; kill asserted mid-BUSY → no ready pulse.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → cyc drops after 4 BUSY cycles, load_fault asserted.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types for the load/store path: LSU state, access size, byte-lane selects.
// Pure declarations; no timing or backpressure of its own.
package core_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_BUSY,
    LSU_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HW,
    SZ_WORD
  } lsu_size_t;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HW   = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Request context kept for the whole bus cycle
  typedef struct packed {
    logic [31:0] addr;
    lsu_size_t   size;
    logic        uns;
  } lsu_req_t;

  function automatic lsu_size_t decode_size(input logic is_byte, input logic is_hw);
    if (is_byte)    return SZ_BYTE;
    else if (is_hw) return SZ_HW;
    else            return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HW:   return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store select/replication on the way out, load shift/extension on the way in.
// Purely combinational, zero latency, no flow control.
module lsu_align
  import core_pkg::*;
(
  input  lsu_size_t   req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] st_dat,
  output logic [3:0]  sel,
  output logic [31:0] st_rep,
  input  lsu_size_t   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_dat
);

  logic [31:0] shifted;

  always_comb begin
    sel    = SEL_WORD;
    st_rep = st_dat;
    case (req_size)
      SZ_BYTE: begin
        sel    = SEL_BYTE << req_off;
        st_rep = {4{st_dat[7:0]}};
      end
      SZ_HW: begin
        sel    = SEL_HW << {req_off[1], 1'b0};
        st_rep = {2{st_dat[15:0]}};
      end
      default: begin
        sel    = SEL_WORD;
        st_rep = st_dat;
      end
    endcase
  end

  assign shifted = ld_raw >> {ld_off, 3'b000};

  always_comb begin
    ld_dat = shifted;
    case (ld_size)
      SZ_BYTE: ld_dat = {{24{~ld_uns & shifted[7]}}, shifted[7:0]};
      SZ_HW:   ld_dat = {{16{~ld_uns & shifted[15]}}, shifted[15:0]};
      default: ld_dat = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one Wishbone classic cycle per MEM request; optional bus timeout under LSU_TIMEOUT_EN.
// Latency: bus ack + 1 cycle to lsu_ready_o, misaligned 1 cycle; stalls the pipeline while a cycle is outstanding.
module lsu
  import core_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic        lsu_read_i,
  input  logic        lsu_write_i,
  input  logic        lsu_byte_i,
  input  logic        lsu_hw_i,
  input  logic        lsu_unsigned_i,
  input  logic        lsu_kill_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ready_o,
  output logic        lsu_stall_o,
  output logic        lsu_load_misaligned_o,
  output logic        lsu_store_misaligned_o,
  output logic        lsu_load_fault_o,
  output logic        lsu_store_fault_o,
  output logic [31:0] lsu_bad_addr_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o
);

  lsu_state_t  state;
  lsu_req_t    req;
  logic        killed;
  logic        req_vld;
  lsu_size_t   size_in;
  logic        mis_in;
  logic [3:0]  sel_in;
  logic [31:0] st_rep_in;
  logic [31:0] ld_ext;
  logic        kill_any;
  logic        bus_fault;

  assign req_vld  = lsu_read_i | lsu_write_i;
  assign size_in  = decode_size(lsu_byte_i, lsu_hw_i);
  assign mis_in   = is_misaligned(size_in, lsu_addr_i[1:0]);
  assign kill_any = killed | lsu_kill_i;

  assign lsu_stall_o = (state == LSU_BUSY) |
                       ((state == LSU_IDLE) & req_vld & ~lsu_kill_i);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Hits on the last tolerated BUSY cycle so cyc drops after exactly TIMEOUT_CYCLES
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_fault = dwbm_err_i | tmo_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (state != LSU_BUSY) begin
      tmo_cnt <= '0;
    end else if (!dwbm_ack_i && !dwbm_err_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign bus_fault = dwbm_err_i;
`endif

  lsu_align u_align (
    .req_size (size_in),
    .req_off  (lsu_addr_i[1:0]),
    .st_dat   (lsu_dat_i),
    .sel      (sel_in),
    .st_rep   (st_rep_in),
    .ld_size  (req.size),
    .ld_off   (req.addr[1:0]),
    .ld_uns   (req.uns),
    .ld_raw   (dwbm_dat_i),
    .ld_dat   (ld_ext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                  <= LSU_IDLE;
      req                    <= '0;
      killed                 <= 1'b0;
      lsu_dat_o              <= '0;
      lsu_ready_o            <= 1'b0;
      lsu_load_misaligned_o  <= 1'b0;
      lsu_store_misaligned_o <= 1'b0;
      lsu_load_fault_o       <= 1'b0;
      lsu_store_fault_o      <= 1'b0;
      lsu_bad_addr_o         <= '0;
      dwbm_addr_o            <= '0;
      dwbm_dat_o             <= '0;
      dwbm_sel_o             <= '0;
      dwbm_cyc_o             <= 1'b0;
      dwbm_stb_o             <= 1'b0;
      dwbm_we_o              <= 1'b0;
    end else begin
      // Result outputs are single-cycle pulses; only the DONE entry sets them
      lsu_dat_o              <= '0;
      lsu_ready_o            <= 1'b0;
      lsu_load_misaligned_o  <= 1'b0;
      lsu_store_misaligned_o <= 1'b0;
      lsu_load_fault_o       <= 1'b0;
      lsu_store_fault_o      <= 1'b0;
      lsu_bad_addr_o         <= '0;

      case (state)
        LSU_IDLE: begin
          if (req_vld && !lsu_kill_i) begin
            req.addr <= lsu_addr_i;
            req.size <= size_in;
            req.uns  <= lsu_unsigned_i;
            killed   <= 1'b0;
            if (mis_in) begin
              state                  <= LSU_DONE;
              lsu_ready_o            <= 1'b1;
              lsu_load_misaligned_o  <= ~lsu_write_i;
              lsu_store_misaligned_o <= lsu_write_i;
              lsu_bad_addr_o         <= lsu_addr_i;
            end else begin
              state       <= LSU_BUSY;
              dwbm_cyc_o  <= 1'b1;
              dwbm_stb_o  <= 1'b1;
              dwbm_we_o   <= lsu_write_i;
              dwbm_addr_o <= {lsu_addr_i[31:2], 2'b00};
              dwbm_sel_o  <= sel_in;
              dwbm_dat_o  <= st_rep_in;
            end
          end
        end

        LSU_BUSY: begin
          if (lsu_kill_i) killed <= 1'b1;
          if (dwbm_ack_i || bus_fault) begin
            state       <= LSU_DONE;
            dwbm_cyc_o  <= 1'b0;
            dwbm_stb_o  <= 1'b0;
            dwbm_we_o   <= 1'b0;
            dwbm_addr_o <= '0;
            dwbm_sel_o  <= '0;
            dwbm_dat_o  <= '0;
            if (!kill_any) begin
              lsu_ready_o <= 1'b1;
              if (bus_fault) begin
                lsu_load_fault_o  <= ~dwbm_we_o;
                lsu_store_fault_o <= dwbm_we_o;
                lsu_bad_addr_o    <= req.addr;
              end else begin
                lsu_dat_o <= ld_ext;
              end
            end
          end
        end

        default: begin
          state <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule
